// File: rtl/rep_id_gen_pkg.sv
// rtl/rep_id_gen_pkg.sv - shared types, constants and helpers for the repeated-pattern ID enumerator
`ifndef DATA_WIDTH
`define DATA_WIDTH 40
`endif
`ifndef LONG_DATA_WIDTH
`define LONG_DATA_WIDTH 64
`endif

package rep_id_gen_pkg;

    localparam int DW      = `DATA_WIDTH;
    localparam int LW      = `LONG_DATA_WIDTH;
    localparam int MAX_DIG = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SCAN,
        S_EMIT,
        S_NEXT,
        S_FIN
    } state_t;

    // One schedule entry: step M, first value 10^(g-1)*M, number of bases 9*10^(g-1),
    // whether multiples of 11 are skipped, and whether this is the last group for its digit count.
    typedef struct packed {
        logic [DW-1:0] m;
        logic [DW-1:0] vstart;
        logic [16:0]   count;
        logic          skip11;
        logic          last;
    } grp_t;

    localparam logic [DW-1:0] POW10 [0:10] = '{
        DW'(64'd1),          DW'(64'd10),          DW'(64'd100),
        DW'(64'd1000),       DW'(64'd10000),       DW'(64'd100000),
        DW'(64'd1000000),    DW'(64'd10000000),    DW'(64'd100000000),
        DW'(64'd1000000000), DW'(64'd10000000000)
    };

    // Decimal digit count, saturating at MAX_DIG+1 for anything wider than the table.
    function automatic logic [3:0] get_digs(input logic [DW-1:0] x);
        logic [3:0] n;
        n = 4'd1;
        for (int i = 1; i <= MAX_DIG; i++) begin
            if (x >= POW10[i]) begin
                n = 4'(i + 1);
            end
        end
        return n;
    endfunction

    function automatic grp_t mk_grp(input int m, input int vstart, input int count,
                                    input bit skip11, input bit last);
        grp_t g;
        g.m      = DW'(m);
        g.vstart = DW'(vstart);
        g.count  = 17'(count);
        g.skip11 = skip11;
        g.last   = last;
        return g;
    endfunction

endpackage

// File: rtl/rep_id_gen_if.sv
// rtl/rep_id_gen_if.sv - request/ID stream bundle; optional REP_ID_GEN_SUM_EN accumulator outputs
interface rep_id_gen_if;
    import rep_id_gen_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_lo;
    logic [DW-1:0] req_hi;
    logic          id_valid;
    logic          id_ready;
    logic [DW-1:0] id_out;
    logic          done;
`ifdef REP_ID_GEN_SUM_EN
    logic [LW-1:0] sum_out;
    logic [31:0]   cnt_out;

    modport master (
        output req_valid, req_lo, req_hi, id_ready,
        input  req_ready, id_valid, id_out, done, sum_out, cnt_out
    );

    modport slave (
        input  req_valid, req_lo, req_hi, id_ready,
        output req_ready, id_valid, id_out, done, sum_out, cnt_out
    );
`else
    modport master (
        output req_valid, req_lo, req_hi, id_ready,
        input  req_ready, id_valid, id_out, done
    );

    modport slave (
        input  req_valid, req_lo, req_hi, id_ready,
        output req_ready, id_valid, id_out, done
    );
`endif

endinterface

// File: rtl/rep_id_gen_group_rom.sv
// rtl/rep_id_gen_group_rom.sv - combinational group schedule lookup (digit count, group index)
module rep_id_gen_group_rom
    import rep_id_gen_pkg::*;
(
    input  logic [3:0] d_i,
    input  logic       gidx_i,
    output grp_t       grp_o
);

    // Group lengths per digit count: 2,3,5,7:{1} 4:{2} 6:{3,2} 8:{4} 9:{3} 10:{5,2}.
    // The g=2 entries of 6 and 10 digits skip bases that are multiples of 11 (single-digit repeats).
    always_comb begin
        grp_o = mk_grp(0, 0, 0, 1'b0, 1'b1);
        case ({d_i, gidx_i})
            5'b0010_0: grp_o = mk_grp(11,        11,         9,     1'b0, 1'b1);
            5'b0011_0: grp_o = mk_grp(111,       111,        9,     1'b0, 1'b1);
            5'b0100_0: grp_o = mk_grp(101,       1010,       90,    1'b0, 1'b1);
            5'b0101_0: grp_o = mk_grp(11111,     11111,      9,     1'b0, 1'b1);
            5'b0110_0: grp_o = mk_grp(1001,      100100,     900,   1'b0, 1'b0);
            5'b0110_1: grp_o = mk_grp(10101,     101010,     90,    1'b1, 1'b1);
            5'b0111_0: grp_o = mk_grp(1111111,   1111111,    9,     1'b0, 1'b1);
            5'b1000_0: grp_o = mk_grp(10001,     10001000,   9000,  1'b0, 1'b1);
            5'b1001_0: grp_o = mk_grp(1001001,   100100100,  900,   1'b0, 1'b1);
            5'b1010_0: grp_o = mk_grp(100001,    1000010000, 90000, 1'b0, 1'b0);
            5'b1010_1: grp_o = mk_grp(101010101, 1010101010, 90,    1'b1, 1'b1);
            default:   grp_o = mk_grp(0, 0, 0, 1'b0, 1'b1);
        endcase
    end

endmodule

// File: rtl/rep_id_gen.sv
// rtl/rep_id_gen.sv - streams every repeated-pattern ID in [lo,hi]; REP_ID_GEN_SUM_EN adds sum/count outputs
module rep_id_gen
    import rep_id_gen_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIG
) (
    input logic         clock,
    input logic         reset,
    rep_id_gen_if.slave bus
);

    state_t        state_q;
    logic          req_ready_q;
    logic          id_valid_q;
    logic          done_q;
    logic [DW-1:0] id_out_q;
    logic [DW-1:0] lo_q;
    logic [DW-1:0] hi_q;
    logic [DW-1:0] value_q;
    logic [DW-1:0] m_q;
    logic [16:0]   left_q;
    logic [3:0]    mod11_q;
    logic [3:0]    d_q;
    logic [3:0]    d_end_q;
    logic          gidx_q;
    logic          skip_en_q;
    logic          last_q;

    logic [DW-1:0] value_d;
    logic [16:0]   left_d;
    logic [3:0]    mod11_d;
    logic [3:0]    d_lo;
    logic [3:0]    d_hi;
    logic [3:0]    d_start;
    logic [3:0]    d_end;
    logic          skip_now;
    grp_t          grp;

    rep_id_gen_group_rom u_rom (
        .d_i    (d_q),
        .gidx_i (gidx_q),
        .grp_o  (grp)
    );

    // Digit counts of the incoming bounds, clamped to the enumerated range.
    assign d_lo    = get_digs(bus.req_lo);
    assign d_hi    = get_digs(bus.req_hi);
    assign d_start = (d_lo < 4'd2) ? 4'd2 : d_lo;
    assign d_end   = (d_hi > 4'(MAX_DIGITS)) ? 4'(MAX_DIGITS) : d_hi;

    // One base step: value tracks base*M by repeated addition; mod11 tracks base mod 11.
    assign value_d  = value_q + m_q;
    assign left_d   = left_q - 17'd1;
    assign mod11_d  = (mod11_q == 4'd10) ? 4'd0 : mod11_q + 4'd1;
    assign skip_now = skip_en_q && (mod11_q == 4'd0);

    // Main sequencer with registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            id_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            id_out_q    <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            value_q     <= '0;
            m_q         <= '0;
            left_q      <= '0;
            mod11_q     <= 4'd10;
            d_q         <= 4'd2;
            d_end_q     <= 4'd2;
            gidx_q      <= 1'b0;
            skip_en_q   <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        lo_q        <= bus.req_lo;
                        hi_q        <= bus.req_hi;
                        d_q         <= d_start;
                        d_end_q     <= d_end;
                        gidx_q      <= 1'b0;
                        req_ready_q <= 1'b0;
                        state_q     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // An empty range (or no digit count to scan) finishes without emitting.
                    if ((lo_q > hi_q) || (d_q > d_end_q)) begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        m_q       <= grp.m;
                        value_q   <= grp.vstart;
                        left_q    <= grp.count;
                        mod11_q   <= 4'd10;
                        skip_en_q <= grp.skip11;
                        last_q    <= grp.last;
                        state_q   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if ((value_q > hi_q) || (left_q == 17'd0)) begin
                        state_q <= S_NEXT;
                    end else if ((value_q < lo_q) || skip_now) begin
                        value_q <= value_d;
                        left_q  <= left_d;
                        mod11_q <= mod11_d;
                    end else begin
                        id_out_q   <= value_q;
                        id_valid_q <= 1'b1;
                        state_q    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (bus.id_ready) begin
                        id_valid_q <= 1'b0;
                        value_q    <= value_d;
                        left_q     <= left_d;
                        mod11_q    <= mod11_d;
                        state_q    <= S_SCAN;
                    end
                end
                S_NEXT: begin
                    if (!last_q) begin
                        gidx_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end else if (d_q >= d_end_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        d_q     <= d_q + 4'd1;
                        gidx_q  <= 1'b0;
                        state_q <= S_SETUP;
                    end
                end
                S_FIN: begin
                    done_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    id_valid_q  <= 1'b0;
                    done_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_out    = id_out_q;
    assign bus.done      = done_q;

`ifdef REP_ID_GEN_SUM_EN
    logic [LW-1:0] sum_q;
    logic [31:0]   cnt_q;

    // Running total of handshaken IDs, cleared when a new request is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else if ((state_q == S_IDLE) && bus.req_valid) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else if ((state_q == S_EMIT) && bus.id_ready) begin
            sum_q <= sum_q + LW'(id_out_q);
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.sum_out = sum_q;
    assign bus.cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_rep_id_gen.sv
// tb/tb_rep_id_gen.sv - directed table-driven bench for rep_id_gen
module tb_rep_id_gen;
    import rep_id_gen_pkg::*;

    localparam int BUDGET = 3000;

    logic clock = 1'b0;
    logic reset;

    rep_id_gen_if bus ();

    rep_id_gen dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
        int            n;
        logic [DW-1:0] id0;
        logic [DW-1:0] id1;
        logic [63:0]   sum;
        int            stall;
        int            done_cyc;
    } vec_t;

    vec_t          vecs [10];
    logic [DW-1:0] got [$];

    function automatic vec_t mkv(input int lo, input int hi, input int n, input int id0,
                                 input int id1, input int sum, input int stall, input int dc);
        vec_t v;
        v.lo       = DW'(lo);
        v.hi       = DW'(hi);
        v.n        = n;
        v.id0      = DW'(id0);
        v.id1      = DW'(id1);
        v.sum      = 64'(sum);
        v.stall    = stall;
        v.done_cyc = dc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int          stall_left;
        int          done_cyc;
        bit          fin;
        logic [63:0] sum;
        logic [63:0] sum_hw;
        logic [63:0] cnt_hw;
        logic [DW-1:0] exp_id;
        logic [DW-1:0] act_id;
        got.delete();
        fin        = 1'b0;
        done_cyc   = -1;
        stall_left = v.stall;
        sum_hw     = '0;
        cnt_hw     = '0;
        @(negedge clock);
        chk($sformatf("v%0d_req_ready", k), 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_lo    = v.lo;
        bus.req_hi    = v.hi;
        bus.id_ready  = (v.stall == 0);
        @(negedge clock);
        bus.req_valid = 1'b0;
        for (int c = 0; c < BUDGET && !fin; c++) begin
            if (c != 0) @(negedge clock);
            if (bus.done) begin
                fin      = 1'b1;
                done_cyc = c;
`ifdef REP_ID_GEN_SUM_EN
                sum_hw = 64'(bus.sum_out);
                cnt_hw = 64'(bus.cnt_out);
`endif
            end else if (bus.id_valid) begin
                if (stall_left > 0) begin
                    bus.id_ready = 1'b0;
                    chk($sformatf("v%0d_hold", k), 64'(bus.id_out), 64'(v.id0));
                    stall_left--;
                end else begin
                    bus.id_ready = 1'b1;
                    got.push_back(bus.id_out);
                end
            end
        end
        chk($sformatf("v%0d_done_seen", k), 64'(fin), 64'd1);
        if (v.done_cyc >= 0) chk($sformatf("v%0d_done_cyc", k), 64'(done_cyc), 64'(v.done_cyc));
        chk($sformatf("v%0d_count", k), 64'(got.size()), 64'(v.n));
        sum = '0;
        for (int i = 0; i < got.size(); i++) sum += 64'(got[i]);
        for (int i = 0; i < v.n; i++) begin
            exp_id = (i == 0) ? v.id0 : v.id1;
            act_id = (i < got.size()) ? got[i] : '1;
            chk($sformatf("v%0d_id%0d", k, i), 64'(act_id), 64'(exp_id));
        end
        chk($sformatf("v%0d_sum", k), sum, v.sum);
`ifdef REP_ID_GEN_SUM_EN
        chk($sformatf("v%0d_sum_out", k), sum_hw, v.sum);
        chk($sformatf("v%0d_cnt_out", k), cnt_hw, 64'(v.n));
`endif
        @(negedge clock);
        chk($sformatf("v%0d_done_pulse", k), 64'(bus.done), 64'd0);
        chk($sformatf("v%0d_idle_ready", k), 64'(bus.req_ready), 64'd1);
        bus.id_ready = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        int dcount;

        vecs[0] = mkv(11, 22, 2, 11, 22, 33, 0, 7);
        vecs[1] = mkv(95, 115, 2, 99, 111, 210, 0, -1);
        vecs[2] = mkv(998, 1012, 2, 999, 1010, 2009, 0, -1);
        vecs[3] = mkv(222220, 222224, 1, 222222, 0, 222222, 0, -1);
        vecs[4] = mkv(11, 22, 2, 11, 22, 33, 5, -1);
        vecs[5] = mkv(50, 40, 0, 0, 0, 0, 0, 1);
        vecs[6] = mkv(1111111111, 1111111111, 1, 1111111111, 0, 1111111111, 0, -1);
        vecs[7] = mkv(0, 9, 0, 0, 0, 0, 0, 1);
        vecs[8] = mkv(1, 11, 1, 11, 0, 11, 0, -1);
        vecs[9] = mkv(12, 21, 0, 0, 0, 0, 0, -1);

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_lo    = '0;
        bus.req_hi    = '0;
        bus.id_ready  = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
        chk("rst_id_out", 64'(bus.id_out), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
`ifdef REP_ID_GEN_SUM_EN
        chk("rst_sum", 64'(bus.sum_out), 64'd0);
        chk("rst_cnt", 64'(bus.cnt_out), 64'd0);
`endif
        reset = 1'b0;

        for (int k = 0; k < 4; k++) run_vec(k, vecs[k]);

        // Reset while an ID is being offered: request aborts with no done pulse.
        @(negedge clock);
        bus.id_ready  = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_lo    = DW'(11);
        bus.req_hi    = DW'(22);
        @(negedge clock);
        bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (bus.id_valid) seen = 1'b1;
            else @(negedge clock);
        end
        chk("mid_rst_reach_emit", 64'(seen), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_id_valid", 64'(bus.id_valid), 64'd0);
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("mid_rst_done", 64'(bus.done), 64'd0);
        chk("mid_rst_id_out", 64'(bus.id_out), 64'd0);
        reset  = 1'b0;
        dcount = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus.done || bus.id_valid) dcount++;
        end
        chk("mid_rst_quiet", 64'(dcount), 64'd0);
        bus.id_ready = 1'b1;

        for (int k = 4; k < 10; k++) run_vec(k, vecs[k]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
